// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants and types for the Y86-64 pipeline hazard controller:
// one-hot status codes, instruction codes, the "no register" ID, the run/halt
// FSM state type, and a helper that classifies a status as exceptional.
// -----------------------------------------------------------------------------
package pipe_pkg;

  // One-hot pipeline status codes
  localparam logic [3:0] STAT_AOK = 4'b0001;
  localparam logic [3:0] STAT_HLT = 4'b0010;
  localparam logic [3:0] STAT_ERR = 4'b0100;  // ADR or INS
  localparam logic [3:0] STAT_BUB = 4'b1000;

  // Instruction codes the controller cares about
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hb;

  localparam logic [3:0] REG_NONE = 4'hf;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2
  } state_e;

  // A bubble status is deliberately not exceptional: only HLT and ERR freeze.
  function automatic logic is_exc(input logic [3:0] stat);
    return (stat == STAT_HLT) || (stat == STAT_ERR);
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// -----------------------------------------------------------------------------
// pipe_hazard_detect
// Purely combinational hazard terms for the pipeline controller.
// Ports:
//   D_icode, E_icode, M_icode  : icodes held in the D, E and M registers
//   d_srcA, d_srcB             : decode source register IDs (REG_NONE = none)
//   E_dstM                     : E-stage memory destination register
//   e_Cnd                      : execute-stage branch condition
//   m_stat, W_stat             : memory-stage and writeback status
//   lu   : load/use hazard     rt : ret in flight     mp : mispredicted jump
//   m_exc, w_exc : memory / writeback status is HLT or ERR
// -----------------------------------------------------------------------------
module pipe_hazard_detect
  import pipe_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  input  logic [3:0] m_stat,
  input  logic [3:0] W_stat,
  output logic       lu,
  output logic       rt,
  output logic       mp,
  output logic       m_exc,
  output logic       w_exc
);

  logic e_is_load;

  assign e_is_load = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);

  // A load targeting REG_NONE writes nothing, so it can never feed decode.
  assign lu = e_is_load && (E_dstM != REG_NONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));

  assign rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);

  assign mp = (E_icode == I_JXX) && !e_Cnd;

  assign m_exc = is_exc(m_stat);
  assign w_exc = is_exc(W_stat);

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline hazard controller for the 5-stage Y86-64 core. Produces stall and
// bubble controls for the F/D/E/M/W registers with zero latency, gated by a
// run/halt state machine that freezes the core once a HLT or ERR status
// reaches writeback.
// Optional feature macro: PIPE_PERF_CNT_EN adds saturating performance
// counters (cyc_cnt, stall_cnt, mispred_cnt, retire_cnt).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   run               : level-sensitive start/resume request
//   D_icode .. W_stat : pipeline state feeding hazard detection
//   F_stall, D_stall, W_stall      : hold the PC / D / W registers
//   D_bubble, E_bubble, M_bubble   : inject nops into D / E / M
//   set_cc            : condition-code write enable
//   halted            : core frozen in HALTED (registered)
//   fault             : halt caused by ERR (registered, sticky until reset)
//   *_cnt             : performance counters (PIPE_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] retire_cnt,
`endif
  output logic             fault
);

  state_e state_q, state_d;
  logic   lu, rt, mp, m_exc, w_exc;
  logic   in_run;

  pipe_hazard_detect u_hazard (
    .D_icode (D_icode),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .E_icode (E_icode),
    .E_dstM  (E_dstM),
    .e_Cnd   (e_Cnd),
    .M_icode (M_icode),
    .m_stat  (m_stat),
    .W_stat  (W_stat),
    .lu      (lu),
    .rt      (rt),
    .mp      (mp),
    .m_exc   (m_exc),
    .w_exc   (w_exc)
  );

  assign in_run = (state_q == ST_RUN);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_run && w_exc) begin
        fault <= (W_stat == STAT_ERR);
      end
    end
  end

  // HALTED is only ever reached through a registered transition.
  assign halted = (state_q == ST_HALTED);

  // NOTE: every output of this block gets a default first (the freeze pattern),
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    F_stall  = 1'b1;
    D_stall  = 1'b1;
    W_stall  = 1'b1;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    set_cc   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        F_stall  = lu | rt;
        D_stall  = lu;
        // A stall on D must win over the ret bubble so D is never both.
        D_bubble = mp | (rt & ~lu);
        E_bubble = mp | lu;
        M_bubble = m_exc | w_exc;
        W_stall  = w_exc;
        set_cc   = (E_icode == I_OPQ) & ~m_exc & ~w_exc;
        // Halting beats a pause request on the same cycle.
        if (w_exc)     state_d = ST_HALTED;
        else if (!run) state_d = ST_IDLE;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef PIPE_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt     <= '0;
      stall_cnt   <= '0;
      mispred_cnt <= '0;
      retire_cnt  <= '0;
    end else if (in_run) begin
      cyc_cnt <= sat_inc(cyc_cnt);
      if (lu | rt)                          stall_cnt   <= sat_inc(stall_cnt);
      if (mp)                               mispred_cnt <= sat_inc(mispred_cnt);
      if ((W_stat == STAT_AOK) && !W_stall) retire_cnt  <= sat_inc(retire_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl. Each scenario task drives a short table of
// pipeline states; the expected control vector for each row is pushed to a
// scoreboard queue as the row is driven and popped when the outputs are
// sampled on the following falling edge.
// Control vector order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble,
//                        W_stall, set_cc, halted, fault}
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;
  import pipe_pkg::*;

  localparam int CNT_W = 32;

  localparam logic [8:0] V_NONE     = 9'b000000000;
  localparam logic [8:0] V_FREEZE   = 9'b110001000;
  localparam logic [8:0] V_FREEZE_H = 9'b110001010;
  localparam logic [8:0] V_FREEZE_F = 9'b110001011;
  localparam logic [8:0] V_LU       = 9'b110100000;
  localparam logic [8:0] V_MP_RT    = 9'b101100000;
  localparam logic [8:0] V_RT       = 9'b101000000;
  localparam logic [8:0] V_CC       = 9'b000000100;
  localparam logic [8:0] V_MEXC     = 9'b000010000;
  localparam logic [8:0] V_WEXC     = 9'b000011000;

  typedef struct packed {
    logic       run;
    logic [3:0] D_icode;
    logic [3:0] d_srcA;
    logic [3:0] d_srcB;
    logic [3:0] E_icode;
    logic [3:0] E_dstM;
    logic       e_Cnd;
    logic [3:0] M_icode;
    logic [3:0] m_stat;
    logic [3:0] W_stat;
  } stim_t;

  logic clk, rst_n, run, e_Cnd;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
  logic halted, fault;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt, stall_cnt, mispred_cnt, retire_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .D_icode    (D_icode),
    .d_srcA     (d_srcA),
    .d_srcB     (d_srcB),
    .E_icode    (E_icode),
    .E_dstM     (E_dstM),
    .e_Cnd      (e_Cnd),
    .M_icode    (M_icode),
    .m_stat     (m_stat),
    .W_stat     (W_stat),
    .F_stall    (F_stall),
    .D_stall    (D_stall),
    .D_bubble   (D_bubble),
    .E_bubble   (E_bubble),
    .M_bubble   (M_bubble),
    .W_stall    (W_stall),
    .set_cc     (set_cc),
    .halted     (halted),
`ifdef PIPE_PERF_CNT_EN
    .cyc_cnt    (cyc_cnt),
    .stall_cnt  (stall_cnt),
    .mispred_cnt(mispred_cnt),
    .retire_cnt (retire_cnt),
`endif
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, need completion");
    $fatal(1, "watchdog");
  end

  function automatic stim_t nop_row(input logic r);
    stim_t s;
    s.run     = r;
    s.D_icode = I_NOP;
    s.d_srcA  = REG_NONE;
    s.d_srcB  = REG_NONE;
    s.E_icode = I_NOP;
    s.E_dstM  = REG_NONE;
    s.e_Cnd   = 1'b1;
    s.M_icode = I_NOP;
    s.m_stat  = STAT_AOK;
    s.W_stat  = STAT_AOK;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    run     = s.run;
    D_icode = s.D_icode;
    d_srcA  = s.d_srcA;
    d_srcB  = s.d_srcB;
    E_icode = s.E_icode;
    E_dstM  = s.E_dstM;
    e_Cnd   = s.e_Cnd;
    M_icode = s.M_icode;
    m_stat  = s.m_stat;
    W_stat  = s.W_stat;
  endtask

  function automatic logic [8:0] ctl_vec();
    return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
            halted, fault};
  endfunction

  // Reset freeze pattern, then IDLE -> RUN on run=1.
  task automatic test_reset();
    stim_t      st[2];
    logic [8:0] ex[2];
    logic [8:0] got, want;
    rst_n = 1'b0;
    apply(nop_row(1'b0));
    exp_q.push_back(V_FREEZE);
    #2;
    got = ctl_vec(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_state: got %b need %b", got, want);
    end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if ({cyc_cnt, stall_cnt, mispred_cnt, retire_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_counters: got %h/%h/%h/%h need all 0",
               cyc_cnt, stall_cnt, mispred_cnt, retire_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    st[0] = nop_row(1'b1); ex[0] = V_FREEZE;  // still IDLE before the edge
    st[1] = nop_row(1'b1); ex[1] = V_NONE;    // now RUN, quiet pipeline
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = ctl_vec(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_run row %0d: got %b need %b", i, got, want);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t      st[4];
    logic [8:0] ex[4];
    logic [8:0] got, want;
    st[0] = nop_row(1'b1); st[0].E_icode = I_MRMOVQ; st[0].E_dstM = 4'd3;
    st[0].d_srcA = 4'd3;   ex[0] = V_LU;
    st[1] = st[0]; st[1].d_srcA = 4'd4; st[1].d_srcB = 4'd4; ex[1] = V_NONE;
    // Load to REG_NONE with no decode sources: no hazard.
    st[2] = nop_row(1'b1); st[2].E_icode = I_POPQ; ex[2] = V_NONE;
    // Load/use coinciding with ret in D: stall wins, no D bubble.
    st[3] = nop_row(1'b1); st[3].E_icode = I_POPQ; st[3].E_dstM = 4'd2;
    st[3].d_srcB = 4'd2;   st[3].D_icode = I_RET; ex[3] = V_LU;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = ctl_vec(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL load_use row %0d: got %b need %b", i, got, want);
      end
    end
  endtask

  task automatic test_mispredict_cc();
    stim_t      st[6];
    logic [8:0] ex[6];
    logic [8:0] got, want;
    st[0] = nop_row(1'b1); st[0].E_icode = I_JXX; st[0].e_Cnd = 1'b0;
    st[0].D_icode = I_RET; ex[0] = V_MP_RT;
    st[1] = nop_row(1'b1); st[1].E_icode = I_JXX; ex[1] = V_NONE;
    st[2] = nop_row(1'b1); st[2].M_icode = I_RET; ex[2] = V_RT;
    st[3] = nop_row(1'b1); st[3].E_icode = I_OPQ; ex[3] = V_CC;
    // Bubble statuses are not exceptions.
    st[4] = st[3]; st[4].m_stat = STAT_BUB; st[4].W_stat = STAT_BUB; ex[4] = V_CC;
    st[5] = st[3]; st[5].m_stat = STAT_HLT; ex[5] = V_MEXC;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = ctl_vec(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mispredict_cc row %0d: got %b need %b", i, got, want);
      end
    end
  endtask

  // run=0 in RUN pauses to IDLE; run=1 resumes.
  task automatic test_pause();
    stim_t      st[4];
    logic [8:0] ex[4];
    logic [8:0] got, want;
    st[0] = nop_row(1'b0); ex[0] = V_NONE;
    st[1] = nop_row(1'b0); ex[1] = V_FREEZE;
    st[2] = nop_row(1'b1); ex[2] = V_FREEZE;
    st[3] = nop_row(1'b1); ex[3] = V_NONE;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = ctl_vec(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pause row %0d: got %b need %b", i, got, want);
      end
    end
  endtask

  // ERR in M, then ERR in W -> HALTED with fault; async reset clears it.
  task automatic test_fault_reset();
    stim_t      st[6];
    logic [8:0] ex[6];
    logic [8:0] got, want;
    st[0] = nop_row(1'b1); st[0].E_icode = I_OPQ; st[0].m_stat = STAT_ERR;
    ex[0] = V_MEXC;
    st[1] = nop_row(1'b1); st[1].E_icode = I_OPQ; st[1].W_stat = STAT_ERR;
    ex[1] = V_WEXC;
    st[2] = nop_row(1'b1); ex[2] = V_FREEZE_F;
    st[3] = nop_row(1'b1); ex[3] = V_FREEZE_F;
    st[4] = nop_row(1'b1); ex[4] = V_FREEZE;  // after async reset, IDLE
    st[5] = nop_row(1'b1); ex[5] = V_NONE;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = ctl_vec(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL fault row %0d: got %b need %b", i, got, want);
      end
      if (i == 3) begin
        // Assert reset between edges; the freeze pattern must appear at once.
        #1;
        rst_n = 1'b0;
        run   = 1'b0;
        exp_q.push_back(V_FREEZE);
        #1;
        got = ctl_vec(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL async_reset: got %b need %b", got, want);
        end
        #1;
        rst_n = 1'b1;
      end
    end
  endtask

  // HLT in W takes priority over run=0; HALTED ignores run.
  task automatic test_halt();
    stim_t      st[4];
    logic [8:0] ex[4];
    logic [8:0] got, want;
    st[0] = nop_row(1'b0); st[0].E_icode = I_OPQ; st[0].W_stat = STAT_HLT;
    ex[0] = V_WEXC;
    st[1] = nop_row(1'b0); ex[1] = V_FREEZE_H;
    st[2] = nop_row(1'b1); ex[2] = V_FREEZE_H;
    st[3] = nop_row(1'b0); ex[3] = V_FREEZE_H;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = ctl_vec(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL halt row %0d: got %b need %b", i, got, want);
      end
    end
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf_cnt();
    logic [4*CNT_W-1:0] got, want;
    stim_t s;
    @(posedge clk); #1;
    apply(nop_row(1'b1));           // IDLE -> RUN on the next edge
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      s = nop_row(i < 9);
      if (i == 3) begin
        s.E_icode = I_MRMOVQ; s.E_dstM = 4'd1; s.d_srcA = 4'd1;
      end
      if (i == 6) begin
        s.E_icode = I_JXX; s.e_Cnd = 1'b0;
      end
      apply(s);
      @(posedge clk);
    end
    @(negedge clk);
    want = {CNT_W'(10), CNT_W'(1), CNT_W'(1), CNT_W'(10)};
    got  = {cyc_cnt, stall_cnt, mispred_cnt, retire_cnt};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL perf_counts: got %h need %h", got, want);
    end
    // Saturation: counter parked at all-ones stays there while running.
    apply(nop_row(1'b1));
    force dut.cyc_cnt = '1;
    @(posedge clk); #1;
    release dut.cyc_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cyc_cnt !== {CNT_W{1'b1}}) begin
      errors++;
      $display("FAIL perf_saturate: got %h need all ones", cyc_cnt);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    apply(nop_row(1'b0));
    test_reset();
    test_load_use();
    test_mispredict_cc();
    test_pause();
    test_fault_reset();
    test_halt();
`ifdef PIPE_PERF_CNT_EN
    test_perf_cnt();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left need 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline hazard controller for the 5-stage Y86-64 core.
- Combinationally generates stall/bubble controls for the F, D, E, M and W pipeline registers from decode/execute/memory/writeback state.
- Adds a registered run/halt state machine that freezes the pipeline once a halting or faulting instruction reaches writeback.
- Optionally maintains performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start/resume request; level-sensitive.
- D_icode  in  4  icode in the D register.
- d_srcA, d_srcB  in  4 each  decode source register IDs; 4'hf means none.
- E_icode  in  4  icode in the E register.
- E_dstM  in  4  E-stage memory destination register.
- e_Cnd  in  1  execute-stage condition result.
- M_icode  in  4  icode in the M register.
- m_stat  in  4  memory-stage status.
- W_stat  in  4  writeback status.
- F_stall  out  1  hold the PC register.
- D_stall  out  1  hold the D register.
- D_bubble  out  1  inject nop into D.
- E_bubble  out  1  inject nop into E.
- M_bubble  out  1  inject nop into M.
- W_stall  out  1  hold the W register.
- set_cc  out  1  condition-code write enable.
- halted  out  1  core frozen (registered).
- fault  out  1  halt was caused by ADR/INS (registered, sticky).

Behaviour:
- Status encoding (one-hot): AOK=4'b0001, HLT=4'b0010, ERR (ADR/INS)=4'b0100, BUB=4'b1000.
- exc(x) is true when x is HLT or ERR.
- Icodes: HALT=0, NOP=1, JXX=7, RET=9, OPQ=6, MRMOVQ=5, POPQ=B.
- Hazard terms:
  - lu = (E_icode==MRMOVQ or POPQ) and E_dstM!=4'hf and E_dstM in {d_srcA, d_srcB}.
  - rt = RET in {D_icode, E_icode, M_icode}.
  - mp = E_icode==JXX and !e_Cnd.
- Controls in RUN state, combinational with zero latency:
  - F_stall = lu|rt
  - D_stall = lu
  - D_bubble = mp | (rt & !lu)
  - E_bubble = mp | lu
  - M_bubble = exc(m_stat) | exc(W_stat)
  - W_stall = exc(W_stat)
  - set_cc = E_icode==OPQ & !exc(m_stat) & !exc(W_stat)
- Priority: D_stall and D_bubble are never both 1. When lu and rt coincide, stall wins.
- FSM states: IDLE, RUN, HALTED. Reset state is IDLE.
  - IDLE: F_stall=D_stall=W_stall=1, all bubbles 0, set_cc=0. Goes to RUN when run=1.
  - RUN: controls as above. If run=0 the next state is IDLE (pause). If exc(W_stat) the next state is HALTED, and this takes priority over run=0. fault<=(W_stat==ERR) on that edge.
  - HALTED: same outputs as IDLE, halted=1. Leaves only via reset; run is ignored.
- Reset values: state=IDLE, halted=0, fault=0, counters=0.
- Reset asserted mid-RUN returns to IDLE immediately (asynchronous). The combinational outputs then show the IDLE freeze pattern.
- BUB in W or M is never treated as exc.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, adds output ports, all CNT_W wide, readable at any time:
  - cyc_cnt: counts every RUN cycle.
  - stall_cnt: counts RUN cycles with lu|rt.
  - mispred_cnt: counts RUN cycles with mp.
  - retire_cnt: counts RUN cycles with W_stat==AOK and !W_stall.
- Counters saturate at all-ones, are frozen outside RUN, and reset to 0.
- When not defined, these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - stat constants (AOK, HLT, ERR, BUB).
  - icode constants.
  - REG_NONE=4'hf.
  - FSM state enum.
- Sub-module pipe_hazard_detect computes the combinational lu/rt/mp/exc terms. pipe_ctrl holds the FSM, output muxing and counters.

Test Plan:
- Load/use: RUN, E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. With d_srcA=4 and d_srcB=4 -> all controls 0.
- Mispredict plus ret: E_icode=7, e_Cnd=0, D_icode=9 -> D_bubble=1, E_bubble=1, F_stall=1, D_stall=0.
- Halt: W_stat=HLT in RUN -> W_stall=1, M_bubble=1, set_cc=0. Next cycle halted=1, fault=0, F/D/W stall=1. A later run=1 pulse leaves halted=1.
- Fault: m_stat=ERR with E_icode=6 -> set_cc=0, M_bubble=1. Then W_stat=ERR -> HALTED with fault=1.
- Reset: rst_n low mid-RUN (async, between edges) -> halted=0, fault=0, freeze pattern shown immediately. run=1 afterwards -> RUN.
- PIPE_PERF_CNT_EN: 10 RUN cycles with one lu and one mp -> cyc_cnt=10, stall_cnt=1, mispred_cnt=1. Preload cyc_cnt to all-ones via force -> it stays at all-ones.
